// File: rtl/if_id_queue.sv
// if_id_queue: circular IF->ID packet queue between fetch and decode.
// Accepts up to three fetched packets per cycle, compacted in program
// order, and presents the three oldest entries to the PC sorter.
// Optional feature: define IF_ID_QUEUE_DROP_CNT_EN to add a 16-bit
// saturating drop_count output that counts cycles in which fetch offered
// packets while the queue could not accept them.

package if_id_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_packet_t;
endpackage

module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  if_id_packet_t              in_packet_0,
  input  if_id_packet_t              in_packet_1,
  input  if_id_packet_t              in_packet_2,
  output logic                       in_ready,
  input  logic [1:0]                 deq_num,
  output if_id_packet_t              out_packet_0,
  output if_id_packet_t              out_packet_1,
  output if_id_packet_t              out_packet_2,
  output logic [$clog2(DEPTH):0]     count
`ifdef IF_ID_QUEUE_DROP_CNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Highest occupancy at which a full group of three still fits.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 3);

  // Storage and pointers
  if_id_packet_t   mem_r      [DEPTH];
  if_id_packet_t   mem_next_s [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [PW-1:0]   head_next_s;
  logic [PW-1:0]   tail_next_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic            in_ready_r;
  logic            in_ready_next_s;

  // Registered output window (oldest three entries)
  if_id_packet_t   out_r      [3];
  if_id_packet_t   out_next_s [3];

  // Enqueue / dequeue bookkeeping
  logic [2:0]      in_valid_s;
  logic            enq_ok_s;
  logic [CW-1:0]   enq_s;
  logic [CW-1:0]   deq_req_s;
  logic [CW-1:0]   deq_s;
  logic [PW-1:0]   pos_1_s;
  logic [PW-1:0]   pos_2_s;

  assign in_valid_s = {in_packet_2.valid, in_packet_1.valid, in_packet_0.valid};

  // Accept decision, compacted write slots and clamped dequeue amount.
  always_comb begin
    enq_ok_s  = 1'b0;
    enq_s     = {CW{1'b0}};
    deq_req_s = {{(CW-2){1'b0}}, deq_num};
    deq_s     = {CW{1'b0}};
    pos_1_s   = tail_r + {{(PW-1){1'b0}}, in_valid_s[0]};
    pos_2_s   = pos_1_s + {{(PW-1){1'b0}}, in_valid_s[1]};
    if (in_ready_r && !flush) begin
      enq_ok_s = 1'b1;
      enq_s    = {{(CW-1){1'b0}}, in_valid_s[0]}
               + {{(CW-1){1'b0}}, in_valid_s[1]}
               + {{(CW-1){1'b0}}, in_valid_s[2]};
    end else begin
      enq_ok_s = 1'b0;
      enq_s    = {CW{1'b0}};
    end
    if (deq_req_s > count_r) begin
      deq_s = count_r;
    end else begin
      deq_s = deq_req_s;
    end
  end

  // Next storage contents, pointers and occupancy; flush overrides all traffic.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_next_s[i] = mem_r[i];
    end
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    count_next_s = count_r;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_next_s[i].valid = 1'b0;
      end
      head_next_s  = {PW{1'b0}};
      tail_next_s  = {PW{1'b0}};
      count_next_s = {CW{1'b0}};
    end else begin
      if (enq_ok_s && in_valid_s[0]) begin
        mem_next_s[tail_r] = in_packet_0;
      end else begin
        mem_next_s[tail_r] = mem_next_s[tail_r];
      end
      if (enq_ok_s && in_valid_s[1]) begin
        mem_next_s[pos_1_s] = in_packet_1;
      end else begin
        mem_next_s[pos_1_s] = mem_next_s[pos_1_s];
      end
      if (enq_ok_s && in_valid_s[2]) begin
        mem_next_s[pos_2_s] = in_packet_2;
      end else begin
        mem_next_s[pos_2_s] = mem_next_s[pos_2_s];
      end
      head_next_s  = head_r + deq_s[PW-1:0];
      tail_next_s  = tail_r + enq_s[PW-1:0];
      count_next_s = count_r + enq_s - deq_s;
    end
  end

  // Next output window and ready flag, so every output leaves a flop.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      out_next_s[k] = '0;
      if (CW'(k) < count_next_s) begin
        out_next_s[k]       = mem_next_s[head_next_s + PW'(k)];
        out_next_s[k].valid = 1'b1;
      end else begin
        out_next_s[k] = '0;
      end
    end
    in_ready_next_s = (count_next_s <= READY_MAX);
  end

  // State register: synchronous reset has priority over flush and traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        out_r[k] <= '0;
      end
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_next_s[i];
      end
      for (int k = 0; k < 3; k++) begin
        out_r[k] <= out_next_s[k];
      end
      head_r     <= head_next_s;
      tail_r     <= tail_next_s;
      count_r    <= count_next_s;
      in_ready_r <= in_ready_next_s;
    end
  end

  assign out_packet_0 = out_r[0];
  assign out_packet_1 = out_r[1];
  assign out_packet_2 = out_r[2];
  assign count        = count_r;
  assign in_ready     = in_ready_r;

`ifdef IF_ID_QUEUE_DROP_CNT_EN
  logic [15:0] drop_count_r;

  // Saturating count of cycles where offered packets were refused.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_r <= 16'h0000;
    end else if (!in_ready_r && !flush && (|in_valid_s) && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'h0001;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  assign drop_count = drop_count_r;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue (DEPTH=8): a driver applies directed
// vectors on the falling edge and queues the hand-computed state expected
// after the next rising edge; a monitor pops and compares after each edge.

module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 8;

  logic          clock;
  logic          reset;
  logic          flush;
  if_id_packet_t in_packet_0, in_packet_1, in_packet_2;
  logic          in_ready;
  logic [1:0]    deq_num;
  if_id_packet_t out_packet_0, out_packet_1, out_packet_2;
  logic [$clog2(DEPTH):0] count;
`ifdef IF_ID_QUEUE_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_packet_0 (in_packet_0),
    .in_packet_1 (in_packet_1),
    .in_packet_2 (in_packet_2),
    .in_ready    (in_ready),
    .deq_num     (deq_num),
    .out_packet_0(out_packet_0),
    .out_packet_1(out_packet_1),
    .out_packet_2(out_packet_2),
    .count       (count)
`ifdef IF_ID_QUEUE_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [2:0]  v;
    logic [31:0] pc0, pc1, pc2;
    logic [1:0]  dq;
    int          ecnt;
    logic        erdy;
    logic [2:0]  ev;
    logic [31:0] e0, e1, e2;
    int          edrop;
  } vec_t;

  typedef struct {
    int            row;
    int            cnt;
    logic          rdy;
    if_id_packet_t o0, o1, o2;
    int            drop;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done_driving = 1'b0;

  function automatic if_id_packet_t mk(input logic v, input logic [31:0] pc);
    if_id_packet_t p;
    p.valid = v;
    p.pc    = pc;
    p.inst  = ~pc;
    return p;
  endfunction

  // Expected output slot: full packet when valid, all zero otherwise.
  function automatic if_id_packet_t exp_pkt(input logic v, input logic [31:0] pc);
    if (v) return mk(1'b1, pc);
    return '0;
  endfunction

  task automatic add(input logic rst, input logic fl, input logic [2:0] v,
                     input logic [31:0] pc0, input logic [31:0] pc1, input logic [31:0] pc2,
                     input logic [1:0] dq, input int ecnt, input logic erdy,
                     input logic [2:0] ev, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] e2, input int edrop);
    vec_t t;
    t.rst = rst; t.fl = fl; t.v = v; t.pc0 = pc0; t.pc1 = pc1; t.pc2 = pc2; t.dq = dq;
    t.ecnt = ecnt; t.erdy = erdy; t.ev = ev; t.e0 = e0; t.e1 = e1; t.e2 = e2; t.edrop = edrop;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [64:0] act, input logic [64:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s row %0d actual %h required %h", name, row, act, expv);
    end
  endtask

  // Monitor: compare DUT state after each rising edge against the scoreboard.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", e.row, 65'(count), 65'(e.cnt));
      chk("in_ready", e.row, 65'(in_ready), 65'(e.rdy));
      chk("out_packet_0", e.row, out_packet_0, e.o0);
      chk("out_packet_1", e.row, out_packet_1, e.o1);
      chk("out_packet_2", e.row, out_packet_2, e.o2);
`ifdef IF_ID_QUEUE_DROP_CNT_EN
      chk("drop_count", e.row, 65'(drop_count), 65'(e.drop));
`endif
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; deq_num = 2'd0;
    in_packet_0 = '0; in_packet_1 = '0; in_packet_2 = '0;

    //   rst   fl    v       pc0       pc1       pc2       dq    cnt rdy   ev      e0        e1        e2        drop
    add(1'b1, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    2'd0, 0,  1'b1, 3'b000, 32'h0,    32'h0,    32'h0,    0);
    add(1'b0, 1'b0, 3'b111, 32'h0,    32'h4,    32'h8,    2'd0, 3,  1'b1, 3'b111, 32'h0,    32'h4,    32'h8,    0);
    add(1'b0, 1'b1, 3'b111, 32'h20,   32'h24,   32'h28,   2'd2, 0,  1'b1, 3'b000, 32'h0,    32'h0,    32'h0,    0);
    add(1'b0, 1'b0, 3'b101, 32'h10,   32'h14,   32'h18,   2'd0, 2,  1'b1, 3'b011, 32'h10,   32'h18,   32'h0,    0);
    add(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    2'd3, 0,  1'b1, 3'b000, 32'h0,    32'h0,    32'h0,    0);
    add(1'b0, 1'b0, 3'b111, 32'h100,  32'h104,  32'h108,  2'd0, 3,  1'b1, 3'b111, 32'h100,  32'h104,  32'h108,  0);
    add(1'b0, 1'b0, 3'b111, 32'h10c,  32'h110,  32'h114,  2'd0, 6,  1'b0, 3'b111, 32'h100,  32'h104,  32'h108,  0);
    add(1'b0, 1'b0, 3'b111, 32'h118,  32'h11c,  32'h120,  2'd0, 6,  1'b0, 3'b111, 32'h100,  32'h104,  32'h108,  1);
    add(1'b0, 1'b0, 3'b111, 32'h200,  32'h204,  32'h208,  2'd1, 5,  1'b1, 3'b111, 32'h104,  32'h108,  32'h10c,  2);
    add(1'b0, 1'b1, 3'b111, 32'h500,  32'h504,  32'h508,  2'd2, 0,  1'b1, 3'b000, 32'h0,    32'h0,    32'h0,    2);
    add(1'b0, 1'b0, 3'b111, 32'h300,  32'h304,  32'h308,  2'd3, 3,  1'b1, 3'b111, 32'h300,  32'h304,  32'h308,  2);
    add(1'b0, 1'b0, 3'b111, 32'h30c,  32'h310,  32'h314,  2'd3, 3,  1'b1, 3'b111, 32'h30c,  32'h310,  32'h314,  2);
    add(1'b0, 1'b0, 3'b111, 32'h318,  32'h31c,  32'h320,  2'd3, 3,  1'b1, 3'b111, 32'h318,  32'h31c,  32'h320,  2);
    add(1'b0, 1'b0, 3'b111, 32'h324,  32'h328,  32'h32c,  2'd3, 3,  1'b1, 3'b111, 32'h324,  32'h328,  32'h32c,  2);
    add(1'b0, 1'b0, 3'b111, 32'h330,  32'h334,  32'h338,  2'd3, 3,  1'b1, 3'b111, 32'h330,  32'h334,  32'h338,  2);
    add(1'b0, 1'b0, 3'b000, 32'h0,    32'h0,    32'h0,    2'd1, 2,  1'b1, 3'b011, 32'h334,  32'h338,  32'h0,    2);
    add(1'b1, 1'b0, 3'b111, 32'h600,  32'h604,  32'h608,  2'd3, 0,  1'b1, 3'b000, 32'h0,    32'h0,    32'h0,    0);
    add(1'b0, 1'b0, 3'b010, 32'h3fc,  32'h400,  32'h404,  2'd0, 1,  1'b1, 3'b001, 32'h400,  32'h0,    32'h0,    0);

    // Driver: apply each vector on the falling edge and queue its expectation.
    for (int r = 0; r < vecs.size(); r++) begin
      exp_t e;
      @(negedge clock);
      reset       = vecs[r].rst;
      flush       = vecs[r].fl;
      deq_num     = vecs[r].dq;
      in_packet_0 = mk(vecs[r].v[0], vecs[r].pc0);
      in_packet_1 = mk(vecs[r].v[1], vecs[r].pc1);
      in_packet_2 = mk(vecs[r].v[2], vecs[r].pc2);
      e.row  = r;
      e.cnt  = vecs[r].ecnt;
      e.rdy  = vecs[r].erdy;
      e.o0   = exp_pkt(vecs[r].ev[0], vecs[r].e0);
      e.o1   = exp_pkt(vecs[r].ev[1], vecs[r].e1);
      e.o2   = exp_pkt(vecs[r].ev[2], vecs[r].e2);
      e.drop = vecs[r].edrop;
      exp_q.push_back(e);
    end
    @(negedge clock);
    reset = 1'b0; flush = 1'b0; deq_num = 2'd0;
    in_packet_0 = '0; in_packet_1 = '0; in_packet_2 = '0;
    done_driving = 1'b1;

    // Bounded drain of the scoreboard.
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
      @(negedge clock);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of IF_ID_PACKET entries; SHALL be a power of two and at least 4.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: flush  input  1  squash all queued packets (branch mispredict / exception).
REQ-005 Port: in_packet_0, in_packet_1, in_packet_2  input  IF_ID_PACKET  fetched packets in program order; the .valid field marks presence.
REQ-006 Port: in_ready  output  1  queue can accept 3 packets this cycle.
REQ-007 Port: deq_num  input  2  number of output packets consumed by decode this cycle (0-3).
REQ-008 Port: out_packet_0, out_packet_1, out_packet_2  output  IF_ID_PACKET  oldest three entries, oldest on _0; these feed the PC sorter ahead of decode.
REQ-009 Port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-010 Storage SHALL be a circular buffer of DEPTH entries with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-011 in_ready SHALL be 1 exactly when count <= DEPTH-3, derived from registered count only; it never depends on deq_num.
REQ-012 When in_ready=1 and flush=0, every input whose .valid=1 SHALL be written at tail, compacted in index order (0 before 1 before 2); invalid inputs are skipped; enq = number of valid inputs.
REQ-013 When in_ready=0, enq SHALL be 0, and all inputs SHALL be ignored.
REQ-014 out_packet_k (k=0..2) SHALL present the entry at head+k (mod DEPTH) with .valid=1 when k < count, otherwise all fields 0 with .valid=0.
REQ-015 Outputs SHALL be driven from registered storage only; a packet enqueued at edge N is first visible on the outputs in the cycle after edge N (one-cycle latency), with no combinational input-to-output path.
REQ-016 Effective dequeue deq SHALL be min(deq_num, count); head advances by deq.
REQ-017 count_next SHALL be count + enq - deq; simultaneous enqueue and dequeue in one cycle are both honoured.
REQ-018 Entry order SHALL be preserved across pointer wrap-around; the oldest packet is always out_packet_0.
REQ-019 flush=1 SHALL, at the next edge, set head=tail=count=0 and clear all entry valid bits, overriding any enqueue and dequeue in the same cycle.
REQ-020 The queue SHALL never overflow; count <= DEPTH at all times.

Reset
REQ-021 On reset=1 at a rising edge: head=0, tail=0, count=0, all entry valid bits 0.
REQ-022 After reset: out_packet_0..2 all-zero with .valid=0; in_ready=1.
REQ-023 Reset SHALL take priority over flush, enqueue and dequeue.
REQ-024 Reset asserted mid-operation SHALL discard all contents.

Configuration
REQ-025 Macro IF_ID_QUEUE_DROP_CNT_EN, when defined, SHALL add output drop_count (16 bits). drop_count increments by 1 each cycle in which in_ready=0, flush=0, and at least one input .valid=1. It saturates at 16'hFFFF and clears on reset only.
REQ-026 When IF_ID_QUEUE_DROP_CNT_EN is undefined, the drop_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset, then 3 valid inputs with PCs 0x0, 0x4, 0x8 and deq_num=0 -> next cycle count=3; outputs carry PCs 0x0, 0x4, 0x8, all valid.
REQ-028 Inputs valid pattern 1-0-1 (PCs 0x10, -, 0x18) into an empty queue -> count=2; out_packet_0=0x10, out_packet_1=0x18, out_packet_2 invalid.
REQ-029 Fill with DEPTH=8: enqueue 3, 3, then 3 -> after two edges count=6 and in_ready=0; the third group is dropped, and count stays 6 (drop_count=1 with macro).
REQ-030 Wrap: enqueue 3 while dequeuing 3 per cycle for 5 cycles -> count=3 and out_packet_0..2 in ascending program order after head wraps past 7.
REQ-031 count=5 with flush=1, valid inputs and deq_num=2 in the same cycle -> next cycle count=0, all outputs invalid, in_ready=1.
REQ-032 count=2 with deq_num=3 -> deq clamps to 2; count becomes 0, with no underflow.
